// File: rtl/dvp_tx_pkg.sv
// Shared types, default frame timing and sizing helpers for the DVP transmit path.
package dvp_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SYNC = 3'd1,
    ST_BP   = 3'd2,
    ST_ACT  = 3'd3,
    ST_FP   = 3'd4
  } dvp_state_e;

  localparam int unsigned DEF_DVP_DATA_W = 8;
  localparam int unsigned DEF_H_ACT      = 1280;
  localparam int unsigned DEF_H_BLK      = 144;
  localparam int unsigned DEF_HS_W       = 16;
  localparam int unsigned DEF_V_SYNC     = 3;
  localparam int unsigned DEF_V_BP       = 17;
  localparam int unsigned DEF_V_ACT      = 480;
  localparam int unsigned DEF_V_FP       = 10;

  // Bits needed to hold 0..n-1, never less than one.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned max4(input int unsigned a, input int unsigned b,
                                       input int unsigned c, input int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/dvp_tx_controller_if.sv
// Byte-stream handshake, run control and DVP output bundle of the transmit controller.
interface dvp_tx_controller_if
  import dvp_tx_pkg::*;
#(
  parameter int unsigned DVP_DATA_W = DEF_DVP_DATA_W
);
  logic                  tx_start_i;
  logic [DVP_DATA_W-1:0] pxl_i;
  logic                  pxl_vld_i;
  logic                  pxl_rdy_o;
  logic                  dvp_pclk_o;
  logic [DVP_DATA_W-1:0] dvp_d_o;
  logic                  dvp_href_o;
  logic                  dvp_vsync_o;
  logic                  dvp_hsync_o;
  logic                  frame_done_o;
  logic                  underflow_o;

  modport master (
    output tx_start_i, pxl_i, pxl_vld_i,
    input  pxl_rdy_o, dvp_pclk_o, dvp_d_o, dvp_href_o, dvp_vsync_o, dvp_hsync_o,
           frame_done_o, underflow_o
  );

  modport slave (
    input  tx_start_i, pxl_i, pxl_vld_i,
    output pxl_rdy_o, dvp_pclk_o, dvp_d_o, dvp_href_o, dvp_vsync_o, dvp_hsync_o,
           frame_done_o, underflow_o
  );
endinterface

// File: rtl/dvp_tx_timing.sv
// Pixel-clock phase, line/frame counters, frame FSM and registered sync/href generation.
module dvp_tx_timing
  import dvp_tx_pkg::*;
#(
  parameter int unsigned H_ACT  = DEF_H_ACT,
  parameter int unsigned H_BLK  = DEF_H_BLK,
  parameter int unsigned HS_W   = DEF_HS_W,
  parameter int unsigned V_SYNC = DEF_V_SYNC,
  parameter int unsigned V_BP   = DEF_V_BP,
  parameter int unsigned V_ACT  = DEF_V_ACT,
  parameter int unsigned V_FP   = DEF_V_FP
) (
  input  logic clk,
  input  logic rst,
  input  logic tx_start,
  output logic pclk,
  output logic href,
  output logic vsync,
  output logic hsync,
  output logic tick,
  output logic act_slot_next,
  output logic sync_entry,
  output logic frame_end
);

  localparam int unsigned LINE = H_ACT + H_BLK;
  localparam int unsigned HW   = cnt_w(LINE);
  localparam int unsigned VW   = cnt_w(max4(V_SYNC, V_BP, V_ACT, V_FP));

  localparam logic [HW-1:0] H_LAST    = HW'(LINE - 1);
  localparam logic [HW-1:0] H_ACT_C   = HW'(H_ACT);
  localparam logic [HW-1:0] H_HS_LAST = HW'(H_ACT + HS_W - 1);
  localparam logic [VW-1:0] VS_LAST   = VW'(V_SYNC - 1);
  localparam logic [VW-1:0] VB_LAST   = VW'(V_BP - 1);
  localparam logic [VW-1:0] VA_LAST   = VW'(V_ACT - 1);
  localparam logic [VW-1:0] VF_LAST   = VW'(V_FP - 1);

  logic          ph;
  dvp_state_e    state, state_nxt;
  logic [HW-1:0] hcnt, hcnt_nxt;
  logic [VW-1:0] vcnt, vcnt_nxt, v_last;
  logic          href_nxt, vsync_nxt, hsync_nxt;

  // state/counters describe the slot currently on the pins; outputs are
  // registered from the *next* slot on each tick so both move together
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ph    <= 1'b0;
      state <= ST_IDLE;
      hcnt  <= '0;
      vcnt  <= '0;
      href  <= 1'b0;
      vsync <= 1'b0;
      hsync <= 1'b0;
    end else begin
      ph <= ~ph;
      if (ph) begin
        state <= state_nxt;
        hcnt  <= hcnt_nxt;
        vcnt  <= vcnt_nxt;
        href  <= href_nxt;
        vsync <= vsync_nxt;
        hsync <= hsync_nxt;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    hcnt_nxt  = hcnt;
    vcnt_nxt  = vcnt;
    case (state)
      ST_SYNC: v_last = VS_LAST;
      ST_BP:   v_last = VB_LAST;
      ST_ACT:  v_last = VA_LAST;
      ST_FP:   v_last = VF_LAST;
      default: v_last = '0;
    endcase
    if (state == ST_IDLE) begin
      hcnt_nxt = '0;
      vcnt_nxt = '0;
      if (tx_start) state_nxt = ST_SYNC;
    end else if (hcnt == H_LAST) begin
      hcnt_nxt = '0;
      if (vcnt == v_last) begin
        vcnt_nxt = '0;
        case (state)
          ST_SYNC: state_nxt = ST_BP;
          ST_BP:   state_nxt = ST_ACT;
          ST_ACT:  state_nxt = ST_FP;
          ST_FP:   state_nxt = tx_start ? ST_SYNC : ST_IDLE;
          default: state_nxt = ST_IDLE;
        endcase
      end else begin
        vcnt_nxt = vcnt + 1'b1;
      end
    end else begin
      hcnt_nxt = hcnt + 1'b1;
    end
  end

  always_comb begin
    href_nxt      = (state_nxt == ST_ACT) && (hcnt_nxt < H_ACT_C);
    hsync_nxt     = (state_nxt == ST_ACT) && (hcnt_nxt >= H_ACT_C) && (hcnt_nxt <= H_HS_LAST);
    vsync_nxt     = (state_nxt == ST_SYNC);
    tick          = ph;
    pclk          = ph;
    act_slot_next = ph && href_nxt;
    sync_entry    = ph && (state_nxt == ST_SYNC) && (state != ST_SYNC);
    frame_end     = ph && (state_nxt == ST_FP) && (hcnt_nxt == H_LAST) && (vcnt_nxt == VF_LAST);
  end

endmodule

// File: rtl/dvp_tx_controller.sv
// DVP transmit controller: frame timing plus byte handshake, data register and status flags.
module dvp_tx_controller
  import dvp_tx_pkg::*;
#(
  parameter int unsigned DVP_DATA_W = DEF_DVP_DATA_W,
  parameter int unsigned H_ACT      = DEF_H_ACT,
  parameter int unsigned H_BLK      = DEF_H_BLK,
  parameter int unsigned HS_W       = DEF_HS_W,
  parameter int unsigned V_SYNC     = DEF_V_SYNC,
  parameter int unsigned V_BP       = DEF_V_BP,
  parameter int unsigned V_ACT      = DEF_V_ACT,
  parameter int unsigned V_FP       = DEF_V_FP
) (
  input logic               clk,
  input logic               rst,
  dvp_tx_controller_if.slave bus
);

  logic                  pclk, href, vsync, hsync;
  logic                  tick, act_slot_next, sync_entry, frame_end;
  logic [DVP_DATA_W-1:0] d_q;
  logic                  underflow_q, frame_done_q;

  dvp_tx_timing #(
    .H_ACT  (H_ACT),
    .H_BLK  (H_BLK),
    .HS_W   (HS_W),
    .V_SYNC (V_SYNC),
    .V_BP   (V_BP),
    .V_ACT  (V_ACT),
    .V_FP   (V_FP)
  ) u_timing (
    .clk           (clk),
    .rst           (rst),
    .tx_start      (bus.tx_start_i),
    .pclk          (pclk),
    .href          (href),
    .vsync         (vsync),
    .hsync         (hsync),
    .tick          (tick),
    .act_slot_next (act_slot_next),
    .sync_entry    (sync_entry),
    .frame_end     (frame_end)
  );

  // A missing byte blanks its slot and flags underflow; timing never stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_q          <= '0;
      underflow_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= frame_end;
      if (tick) begin
        d_q <= (act_slot_next && bus.pxl_vld_i) ? bus.pxl_i : '0;
        if (sync_entry)
          underflow_q <= 1'b0;
        else if (act_slot_next && !bus.pxl_vld_i)
          underflow_q <= 1'b1;
      end
    end
  end

  assign bus.pxl_rdy_o    = act_slot_next;
  assign bus.dvp_pclk_o   = pclk;
  assign bus.dvp_d_o      = d_q;
  assign bus.dvp_href_o   = href;
  assign bus.dvp_vsync_o  = vsync;
  assign bus.dvp_hsync_o  = hsync;
  assign bus.frame_done_o = frame_done_q;
  assign bus.underflow_o  = underflow_q;

endmodule

// File: tb/tb_dvp_tx_controller.sv
// Directed and randomized frames checked slot by slot against a frame-position model.
module tb_dvp_tx_controller;

  localparam int T_H_ACT  = 4;
  localparam int T_H_BLK  = 2;
  localparam int T_HS_W   = 1;
  localparam int T_V_SYNC = 1;
  localparam int T_V_BP   = 1;
  localparam int T_V_ACT  = 2;
  localparam int T_V_FP   = 1;
  localparam int LINE     = T_H_ACT + T_H_BLK;
  localparam int FSLOTS   = LINE * (T_V_SYNC + T_V_BP + T_V_ACT + T_V_FP);

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  bit   m_uf = 1'b0;

  dvp_tx_controller_if #(.DVP_DATA_W(8)) bus ();

  dvp_tx_controller #(
    .DVP_DATA_W (8),
    .H_ACT      (T_H_ACT),
    .H_BLK      (T_H_BLK),
    .HS_W       (T_HS_W),
    .V_SYNC     (T_V_SYNC),
    .V_BP       (T_V_BP),
    .V_ACT      (T_V_ACT),
    .V_FP       (T_V_FP)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic bit slot_act(input int s);
    int ln, col;
    ln  = s / LINE;
    col = s % LINE;
    return (ln >= T_V_SYNC + T_V_BP) && (ln < T_V_SYNC + T_V_BP + T_V_ACT) && (col < T_H_ACT);
  endfunction

  function automatic bit slot_hsync(input int s);
    int ln, col;
    ln  = s / LINE;
    col = s % LINE;
    return (ln >= T_V_SYNC + T_V_BP) && (ln < T_V_SYNC + T_V_BP + T_V_ACT) &&
           (col >= T_H_ACT) && (col < T_H_ACT + T_HS_W);
  endfunction

  function automatic bit slot_vsync(input int s);
    return (s / LINE) < T_V_SYNC;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag, input bit pclk, input logic [7:0] d, input bit href,
                            input bit vs, input bit hs, input bit fd, input bit uf);
    check({tag, "_pclk"},  bus.dvp_pclk_o,   pclk);
    check({tag, "_d"},     bus.dvp_d_o,      d);
    check({tag, "_href"},  bus.dvp_href_o,   href);
    check({tag, "_vsync"}, bus.dvp_vsync_o,  vs);
    check({tag, "_hsync"}, bus.dvp_hsync_o,  hs);
    check({tag, "_fdone"}, bus.frame_done_o, fd);
    check({tag, "_uflow"}, bus.underflow_o,  uf);
  endtask

  // Assumes the current clk has ph==1, so the next edge is a tick.
  // mode 0: bytes 1,2,3.. always valid; 1: as 0 but 3rd byte of first frame missing; 2: random.
  task automatic run_frames(input int nfr, input int mode, input int stop_at, input int abort_at);
    int          byte_n;
    int          xfers, exp_xfers;
    bit          a, v;
    logic [7:0]  p, exp_d;
    byte_n = 0;
    for (int f = 0; f < nfr; f++) begin
      xfers     = 0;
      exp_xfers = 0;
      for (int s = 0; s < FSLOTS; s++) begin
        if (f == nfr - 1 && s == abort_at) return;
        a = slot_act(s);
        bus.tx_start_i = (f < nfr - 1) || (s < stop_at);
        if (a) begin
          case (mode)
            0: begin p = 8'(byte_n + 1); v = 1'b1; end
            1: begin p = 8'(byte_n + 1); v = !(f == 0 && byte_n == 2); end
            default: begin p = 8'($urandom); v = ($urandom_range(0, 4) != 0); end
          endcase
          byte_n++;
        end else begin
          p = 8'($urandom);
          v = 1'($urandom_range(0, 1));
        end
        bus.pxl_i     = p;
        bus.pxl_vld_i = v;
        #1;
        check("rdy_pre", bus.pxl_rdy_o, a);
        if (bus.pxl_rdy_o && v) xfers++;
        if (a && v) exp_xfers++;
        exp_d = (a && v) ? p : 8'h00;
        if (s == 0) m_uf = 1'b0;
        if (a && !v) m_uf = 1'b1;
        @(posedge clk); #1;
        check_outs("tick", 1'b0, exp_d, a, slot_vsync(s), slot_hsync(s), s == FSLOTS - 1, m_uf);
        check("rdy_post", bus.pxl_rdy_o, 1'b0);
        @(posedge clk); #1;
        check_outs("hold", 1'b1, exp_d, a, slot_vsync(s), slot_hsync(s), 1'b0, m_uf);
      end
      check("xfers", xfers, exp_xfers);
      if (mode != 2) check("xfers_full", exp_xfers, 32'(T_H_ACT * T_V_ACT - ((mode == 1 && f == 0) ? 1 : 0)));
    end
  endtask

  task automatic idle_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      bus.tx_start_i = 1'b0;
      bus.pxl_vld_i  = 1'b1;
      bus.pxl_i      = 8'($urandom);
      #1;
      check("idle_rdy", bus.pxl_rdy_o, 1'b0);
      @(posedge clk); #1;
      check_outs("idle_tick", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, m_uf);
      @(posedge clk); #1;
      check("idle_pclk", bus.dvp_pclk_o, 1'b1);
    end
  endtask

  task automatic do_reset();
    rst            = 1'b1;
    bus.tx_start_i = 1'b1;
    bus.pxl_vld_i  = 1'b1;
    bus.pxl_i      = 8'hA5;
    m_uf           = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_outs("rst_hold", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("rst_rdy", bus.pxl_rdy_o, 1'b0);
    rst = 1'b0;
    @(posedge clk); #1;
    check_outs("rst_rel", 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    bus.tx_start_i = 1'b0;
    bus.pxl_i      = '0;
    bus.pxl_vld_i  = 1'b0;

    do_reset();
    run_frames(1, 0, FSLOTS - 5, -1);   // normal frame
    idle_ticks(3);
    run_frames(2, 1, FSLOTS - 5, -1);   // underflow, then clears on next vsync
    idle_ticks(2);
    run_frames(2, 0, FSLOTS - 5, -1);   // back-to-back
    idle_ticks(2);
    run_frames(1, 0, 13, -1);           // start drops in ACT line 0
    idle_ticks(3);
    run_frames(3, 2, FSLOTS - 5, -1);   // randomized
    idle_ticks(2);

    run_frames(1, 2, FSLOTS, 14);       // abort inside ACT, then async reset
    check("pre_rst_href", bus.dvp_href_o, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    m_uf = 1'b0;
    check_outs("async_rst", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("async_rst_rdy", bus.pxl_rdy_o, 1'b0);
    do_reset();
    run_frames(1, 2, FSLOTS - 5, -1);
    idle_ticks(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
